// File: rtl/counter_sweep_if.sv
// Command and status bundle for counter_sweep_ctrl: the host drives the
// commands and limits, the controller returns the counter state.
interface counter_sweep_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] lo_lim;
   logic [WIDTH-1:0] hi_lim;
   logic [WIDTH-1:0] count;
   logic             up_down;
   logic             busy;
   logic             turn;
   logic [7:0]       sweeps;
   logic             lim_err;

   modport master (
      output start, stop, lo_lim, hi_lim,
      input  count, up_down, busy, turn, sweeps, lim_err
   );

   modport slave (
      input  start, stop, lo_lim, hi_lim,
      output count, up_down, busy, turn, sweeps, lim_err
   );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Up/down sweep counter bouncing between latched limits without repeating endpoints.
// Optional endpoint dwell (count held DWELL cycles at each limit) enabled by SWEEP_DWELL_EN.
module counter_sweep_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DWELL = 2
) (
   input logic            clk,
   input logic            reset,
   counter_sweep_if.slave bus
);

`ifdef SWEEP_DWELL_EN
   localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_DWELL_HI, S_DWELL_LO} state_t;

   logic [DCW-1:0] dwell_cnt;
   logic           dwell_done;

   // Last dwell cycle: reversal happens on the following edge
   assign dwell_done = (DWELL <= 1) || (dwell_cnt == DCW'(DWELL - 1));
`else
   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

   // DWELL only matters when the dwell states are compiled in
   if (DWELL > 0) begin : g_dwell_unused
   end
`endif

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] lo_lat;
   logic [WIDTH-1:0] hi_lat;
   logic             up_down;
   logic             busy;
   logic             turn;
   logic [7:0]       sweeps;
   logic             lim_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         count   <= '0;
         lo_lat  <= '0;
         hi_lat  <= '0;
         up_down <= 1'b0;
         busy    <= 1'b0;
         turn    <= 1'b0;
         sweeps  <= 8'd0;
         lim_err <= 1'b0;
`ifdef SWEEP_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         turn    <= 1'b0;
         lim_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.stop) begin
                  if (bus.lo_lim < bus.hi_lim) begin
                     lo_lat  <= bus.lo_lim;
                     hi_lat  <= bus.hi_lim;
                     count   <= bus.lo_lim;
                     up_down <= 1'b1;
                     sweeps  <= 8'd0;
                     busy    <= 1'b1;
                     state   <= S_UP;
                  end else begin
                     lim_err <= 1'b1;
                  end
               end
            end
            S_UP: begin
               if (bus.stop) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (count < hi_lat) begin
                  count <= count + WIDTH'(1);
               end else begin
`ifdef SWEEP_DWELL_EN
                  dwell_cnt <= '0;
                  state     <= S_DWELL_HI;
`else
                  count   <= hi_lat - WIDTH'(1);
                  up_down <= 1'b0;
                  turn    <= 1'b1;
                  state   <= S_DOWN;
`endif
               end
            end
            S_DOWN: begin
               if (bus.stop) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (count > lo_lat) begin
                  count <= count - WIDTH'(1);
               end else begin
`ifdef SWEEP_DWELL_EN
                  dwell_cnt <= '0;
                  state     <= S_DWELL_LO;
`else
                  count   <= lo_lat + WIDTH'(1);
                  up_down <= 1'b1;
                  turn    <= 1'b1;
                  if (sweeps != 8'hFF) sweeps <= sweeps + 8'd1;
                  state   <= S_UP;
`endif
               end
            end
`ifdef SWEEP_DWELL_EN
            S_DWELL_HI: begin
               if (bus.stop) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (!dwell_done) begin
                  dwell_cnt <= dwell_cnt + DCW'(1);
               end else begin
                  count   <= hi_lat - WIDTH'(1);
                  up_down <= 1'b0;
                  turn    <= 1'b1;
                  state   <= S_DOWN;
               end
            end
            S_DWELL_LO: begin
               if (bus.stop) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (!dwell_done) begin
                  dwell_cnt <= dwell_cnt + DCW'(1);
               end else begin
                  count   <= lo_lat + WIDTH'(1);
                  up_down <= 1'b1;
                  turn    <= 1'b1;
                  if (sweeps != 8'hFF) sweeps <= sweeps + 8'd1;
                  state   <= S_UP;
               end
            end
`endif
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.count   = count;
   assign bus.up_down = up_down;
   assign bus.busy    = busy;
   assign bus.turn    = turn;
   assign bus.sweeps  = sweeps;
   assign bus.lim_err = lim_err;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Randomized and directed bench for counter_sweep_ctrl against an index-based
// model of one sweep period; honours SWEEP_DWELL_EN when defined.
module tb_counter_sweep_ctrl;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DWELL = 2;
`ifdef SWEEP_DWELL_EN
   localparam int DW = DWELL;
`else
   localparam int DW = 0;
`endif

   logic clk = 1'b0;
   logic reset;

   counter_sweep_if #(.WIDTH(WIDTH)) bus_if ();

   counter_sweep_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: a sweep is a periodic list of values indexed by m_idx.
   // Index 0 is the start value; the period then runs 1..len and wraps to 1.
   bit m_busy, m_dir, m_turn, m_lerr;
   int m_idx, m_lo, m_hi, m_sweeps, m_count;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int seq_val(input int i);
      int n;
      n = m_hi - m_lo;
      if (i <= n)          return m_lo + i;
      if (i <= n + DW)     return m_hi;
      if (i <= 2 * n + DW) return m_hi - (i - n - DW);
      return m_lo;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_dir = 0; m_turn = 0; m_lerr = 0;
      m_idx = 0; m_lo = 0; m_hi = 0; m_sweeps = 0; m_count = 0;
   endtask

   task automatic model_next(input bit st, input bit sp, input int lo, input int hi);
      int n, len, nxt;
      m_turn = 0;
      m_lerr = 0;
      if (!m_busy) begin
         if (st && !sp) begin
            if (lo < hi) begin
               m_busy = 1; m_lo = lo; m_hi = hi; m_idx = 0;
               m_sweeps = 0; m_count = lo; m_dir = 1;
            end else begin
               m_lerr = 1;
            end
         end
      end else if (sp) begin
         m_busy = 0;
      end else begin
         n   = m_hi - m_lo;
         len = 2 * n + 2 * DW;
         nxt = (m_idx == len) ? 1 : m_idx + 1;
         if (nxt == n + DW + 1) m_turn = 1;
         if (m_idx == len) begin
            m_turn = 1;
            if (m_sweeps < 255) m_sweeps++;
         end
         m_idx   = nxt;
         m_count = seq_val(nxt);
         m_dir   = (nxt <= n + DW);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".count"},   32'(bus_if.count),   32'(m_count));
      chk({ctx, ".up_down"}, 32'(bus_if.up_down), 32'(m_dir));
      chk({ctx, ".busy"},    32'(bus_if.busy),    32'(m_busy));
      chk({ctx, ".turn"},    32'(bus_if.turn),    32'(m_turn));
      chk({ctx, ".sweeps"},  32'(bus_if.sweeps),  32'(m_sweeps));
      chk({ctx, ".lim_err"}, 32'(bus_if.lim_err), 32'(m_lerr));
   endtask

   // Apply inputs at the falling edge, clock once, check at the next falling edge
   task automatic step(input string ctx, input bit st, input bit sp, input int lo, input int hi);
      bus_if.start  = st;
      bus_if.stop   = sp;
      bus_if.lo_lim = WIDTH'(lo);
      bus_if.hi_lim = WIDTH'(hi);
      model_next(st, sp, lo, hi);
      @(posedge clk);
      @(negedge clk);
      check_all(ctx);
   endtask

   initial begin
      int exp_seq[$];
      int lo0, hi0, k;
      bit hit;

      reset = 1'b1;
      bus_if.start = 1'b0; bus_if.stop = 1'b0;
      bus_if.lo_lim = '0;  bus_if.hi_lim = '0;
      model_reset();
      #3;
      check_all("rst");
      @(negedge clk);
      reset = 1'b0;

      // Basic sweep sequence with fixed expected values
`ifdef SWEEP_DWELL_EN
      lo0 = 1; hi0 = 3; exp_seq = '{1, 2, 3, 3, 3, 2, 1, 1, 1, 2};
`else
      lo0 = 2; hi0 = 5; exp_seq = '{2, 3, 4, 5, 4, 3, 2, 3};
`endif
      step("seq", 1, 0, lo0, hi0);
      chk("seq.v0", 32'(bus_if.count), 32'(exp_seq[0]));
      for (int i = 1; i < exp_seq.size(); i++) begin
         step("seq", 0, 0, 0, 0);
         chk($sformatf("seq.v%0d", i), 32'(bus_if.count), 32'(exp_seq[i]));
      end
      chk("seq.sweeps1", 32'(bus_if.sweeps), 32'd1);
      step("seq.stop", 0, 1, 0, 0);

      // Rejected starts: equal and inverted limits
      step("lim77", 1, 0, 7, 7);
      chk("lim77.err", 32'(bus_if.lim_err), 32'd1);
      chk("lim77.busy", 32'(bus_if.busy), 32'd0);
      step("lim93", 1, 0, 9, 3);
      chk("lim93.err", 32'(bus_if.lim_err), 32'd1);
      step("lim.idle", 0, 0, 0, 0);

      // Full-range sweep, limit change while busy, stop at top
      step("full", 1, 0, 0, 15);
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step("full", 0, 0, 0, (i >= 5) ? 3 : 15);
         if (m_count == 15) hit = 1;
      end
      chk("full.reach15", 32'(hit), 32'd1);
      step("full.stop", 0, 1, 0, 3);
      chk("full.hold15", 32'(bus_if.count), 32'd15);
      chk("full.noturn", 32'(bus_if.turn), 32'd0);
      step("full.idle", 0, 0, 0, 0);

      // start+stop together in IDLE, then start while busy
      step("ss", 1, 1, 2, 5);
      chk("ss.busy", 32'(bus_if.busy), 32'd0);
      step("ss.go", 1, 0, 2, 5);
      step("ss.rest", 1, 0, 0, 1);
      chk("ss.count", 32'(bus_if.count), 32'd3);
      step("ss.stop", 0, 1, 0, 0);

      // Asynchronous reset between edges while counting down
      step("ar", 1, 0, 2, 6);
      hit = 0;
      for (int i = 0; i < 30 && !hit; i++) begin
         step("ar", 0, 0, 0, 0);
         if (!m_dir) hit = 1;
      end
      chk("ar.down", 32'(hit), 32'd1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("ar.count0", 32'(bus_if.count), 32'd0);
      chk("ar.busy0", 32'(bus_if.busy), 32'd0);
      chk("ar.sweeps0", 32'(bus_if.sweeps), 32'd0);
      check_all("ar");
      @(negedge clk);
      reset = 1'b0;
      step("ar.idle", 0, 0, 0, 0);
      step("ar.idle", 0, 0, 0, 0);

      // Sweep counter saturation on the tightest range
      step("sat", 1, 0, 0, 1);
      k = 2 * (1 + DW) * 256 + 10;
      for (int i = 0; i < k; i++) step("sat", 0, 0, 0, 0);
      chk("sat.255", 32'(bus_if.sweeps), 32'd255);
      step("sat.stop", 0, 1, 0, 0);

      // Random commands and limits
      for (int i = 0; i < 600; i++) begin
         step("rnd", ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the count width in bits.
REQ-002 The block SHALL have parameter DWELL, default 2, giving the endpoint hold length in cycles; it is used only under REQ-030.
REQ-003 Port clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  level-sampled command that begins a sweep from IDLE.
REQ-006 Port stop  input  1  level-sampled command that aborts a sweep and returns to IDLE.
REQ-007 Port lo_lim  input  WIDTH  lower sweep limit, unsigned.
REQ-008 Port hi_lim  input  WIDTH  upper sweep limit, unsigned.
REQ-009 Port count  output  WIDTH  current counter value, registered.
REQ-010 Port up_down  output  1  current direction, registered: 1 = up, 0 = down.
REQ-011 Port busy  output  1  high in every state except IDLE.
REQ-012 Port turn  output  1  one-cycle pulse on the cycle count reverses direction at either limit.
REQ-013 Port sweeps  output  8  number of completed lo-to-hi-to-lo round trips; saturates at 255.
REQ-014 Port lim_err  output  1  one-cycle pulse when start is rejected for invalid limits.

Function
REQ-015 The state machine SHALL have states IDLE, UP and DOWN, plus DWELL_HI and DWELL_LO when REQ-030 applies.
REQ-016 IDLE, start=1, stop=0, lo_lim<hi_lim:
- next edge latches both limits, loads count=lo_lim, sets up_down=1, enters UP;
- sweeps is cleared to 0 on the same edge.
REQ-017 IDLE, start=1, lo_lim>=hi_lim: the FSM SHALL remain in IDLE, leave count unchanged and assert lim_err for exactly one cycle.
REQ-018 Limit inputs SHALL be ignored while busy=1; only the values latched at start apply.
REQ-019 UP: if count<hi_lat, count increments by 1 each cycle.
REQ-020 UP: if count==hi_lat, the next edge sets count=hi_lat-1, sets up_down=0 and pulses turn, and the FSM enters DOWN.
REQ-021 DOWN: if count>lo_lat, count decrements by 1 each cycle.
REQ-022 DOWN: if count==lo_lat, the next edge sets count=lo_lat+1, sets up_down=1, pulses turn and increments sweeps (saturating), and the FSM enters UP.
REQ-023 Resulting sequence for lo=2, hi=5: 2,3,4,5,4,3,2,3,...; no endpoint value is repeated; count never leaves [lo_lat, hi_lat] and never wraps.
REQ-024 stop=1 in any busy state: the next edge enters IDLE, count and up_down hold, and no turn pulse occurs even at a limit.
REQ-025 start and stop asserted in the same cycle: stop wins; from IDLE nothing happens.
REQ-026 start asserted while busy SHALL be ignored.
REQ-027 In IDLE, count, up_down and sweeps SHALL hold their last values; turn=0 and lim_err=0 except as required by REQ-017.

Reset
REQ-028 reset=1 SHALL immediately force, independent of clk:
- FSM to IDLE; count=0; up_down=0; busy=0; turn=0; sweeps=0; lim_err=0; latched limits to 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; after release the block waits in IDLE for a new start.

Configuration
REQ-030 Macro SWEEP_DWELL_EN:
- Defined: reaching hi_lat in UP enters DWELL_HI and reaching lo_lat in DOWN enters DWELL_LO.
- In a dwell state, count holds for DWELL cycles, then the REQ-020/REQ-022 reversal actions occur on the following edge.
- turn pulses on that reversal edge; stop in a dwell state returns to IDLE.
- Not defined: the dwell states and the DWELL parameter have no effect, and reversal occurs as in REQ-020/REQ-022.

Verification
REQ-031 Reset, then start with lo=2, hi=5 -> count 2,3,4,5,4,3,2,3; turn high on the edges producing 4 and 3; sweeps=1 after the first return to 2.
REQ-032 start with lo=7, hi=7, then with lo=9, hi=3 -> each attempt: one-cycle lim_err, busy=0, count unchanged.
REQ-033 Sweeping 0..15 with WIDTH=4, change hi_lim to 3 mid-sweep, then stop at count=15 -> count still reaches 15 with no wrap to 0; after stop, IDLE with count=15 held and no turn pulse.
REQ-034 start and stop asserted together in IDLE, then start alone while in UP -> no state change in either case.
REQ-035 Assert reset asynchronously between edges during DOWN -> count=0, busy=0 and sweeps=0 immediately, before the next clk edge.
REQ-036 With SWEEP_DWELL_EN and DWELL=2, lo=1, hi=3 -> count 1,2,3,3,3,2,1,1,1,2.
